sram_2147_ctrl: RTL

Synchronous initiator that runs read and write cycles on a bank of DATA_W parallel 4k x 1 static RAMs of the 2147 type. Each part has a shared 12-bit address, an active-low chip enable and an active-low write enable. The block turns a simple req/ack request port into correctly sequenced, glitch-free CE_N/WE_N strobes with programmable setup, strobe and access timing. It sits between a CPU-side memory client (e.g. a control-memory loader or debug port) and the physical RAM bank.

---
 rtl/sram_ctrl_pkg.sv | 31 +++
 rtl/sram_ctrl_timer.sv | 36 +++
 rtl/sram_2147_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the 2147-type SRAM bank controller.
//   - state_t        : controller FSM states
//   - SRAM_ADDR_W    : address width of a 4k x 1 part (12)
//   - tmr_width()    : width of the phase timer for the given cycle counts
//   - TMR_W_DEFAULT  : timer width for the default timing (2/2)
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ACCESS = 3'd4
  } state_t;

  // The timer is loaded with the longer of the two phase lengths, so it must
  // be able to hold max(access_cyc, we_cyc).
  function automatic int tmr_width(input int access_cyc, input int we_cyc);
    int m;
    m = (access_cyc > we_cyc) ? access_cyc : we_cyc;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

  localparam int TMR_W_DEFAULT = tmr_width(2, 2);

endpackage

// File: rtl/sram_ctrl_timer.sv
// -----------------------------------------------------------------------------
// sram_ctrl_timer
// Loadable down-counter used to time the STROBE and ACCESS phases.
// Loading value N makes o_done high on the N-th cycle after the load edge,
// so a state that exits on o_done lasts exactly N cycles.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   i_load       : load i_val on this edge
//   i_val        : phase length in cycles (>=1)
//   o_done       : last cycle of the loaded phase
// -----------------------------------------------------------------------------
module sram_ctrl_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/sram_2147_ctrl.sv
// -----------------------------------------------------------------------------
// sram_2147_ctrl
// Initiator for a bank of DATA_W parallel 4k x 1 static RAMs (2147 type).
// Converts a req/ready/ack client port into registered CE_N / WE_N strobes.
//
// Client handshake: a request is taken on the rising edge where req && ready.
// ready is high only while idle; it drops on the accept edge and stays low
// through the ack cycle, rising one cycle after ack. ack is a one-cycle pulse
// when the RAM cycle finishes; after a read, rdata is valid with ack and holds
// until the next read finishes. req while ready=0 is ignored.
//
// Write: CE_N falls on accept, SETUP (1) -> STROBE (WE_CYC, WE_N low)
//        -> HOLD (1) -> ack. Latency accept->ack = WE_CYC+2.
// Read : CE_N falls on accept, SETUP (1) -> ACCESS (ACCESS_CYC) -> rdata
//        sampled, CE_N high, ack. Latency accept->ack = ACCESS_CYC+1.
//
// Ports: clk, reset_n (async, active-low); req, we, addr, wdata (request);
//        ready, ack, rdata (response); sram_a, sram_ce_n, sram_we_n, sram_di,
//        sram_do (RAM bank); o_dbg_state (current FSM state).
// Optional macro SRAM_CTRL_PARITY_EN adds sram_di_p, sram_do_p, par_err
// (even parity bit stored alongside each word, checked on reads).
// All outputs come directly from flops.
// -----------------------------------------------------------------------------
module sram_2147_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int ACCESS_CYC = 2,
  parameter int WE_CYC     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do,
`ifdef SRAM_CTRL_PARITY_EN
  output logic              sram_di_p,
  input  logic              sram_do_p,
  output logic              par_err,
`endif
  output state_t            o_dbg_state
);

  localparam int TW = tmr_width(ACCESS_CYC, WE_CYC);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_op_we;
  logic              r_ready;
  logic              r_ack;
  logic              r_ce_n;
  logic              r_we_n;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_di;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_op_we_nxt;
  logic              w_ready_nxt;
  logic              w_ack_nxt;
  logic              w_ce_n_nxt;
  logic              w_we_n_nxt;
  logic [ADDR_W-1:0] w_a_nxt;
  logic [DATA_W-1:0] w_di_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_tmr_load;
  logic [TW-1:0]     w_tmr_val;
  logic              w_tmr_done;

  assign w_accept = (r_state == ST_IDLE) && req && r_ready;

  sram_ctrl_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_tmr_load),
    .i_val   (w_tmr_val),
    .o_done  (w_tmr_done)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)   w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = r_op_we ? ST_STROBE : ST_ACCESS;
      ST_STROBE: if (w_tmr_done) w_state_nxt = ST_HOLD;
      ST_HOLD:   w_state_nxt = ST_IDLE;
      ST_ACCESS: if (w_tmr_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs. Each strobe moves on
  // a different edge (CE_N first, WE_N one cycle later, WE_N released one
  // cycle before CE_N), so WE_N low always lies strictly inside CE_N low.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_op_we_nxt = r_op_we;
    w_ready_nxt = r_ready;
    w_ack_nxt   = 1'b0;
    w_ce_n_nxt  = r_ce_n;
    w_we_n_nxt  = r_we_n;
    w_a_nxt     = r_a;
    w_di_nxt    = r_di;
    w_rdata_nxt = r_rdata;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_op_we_nxt = we;
          w_ready_nxt = 1'b0;
          w_ce_n_nxt  = 1'b0;
          w_a_nxt     = addr;
          w_di_nxt    = wdata;
        end else begin
          // Raised one cycle after ack, keeping ready low through the ack cycle.
          w_ready_nxt = 1'b1;
        end
      end
      ST_SETUP: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = r_op_we ? TW'(WE_CYC) : TW'(ACCESS_CYC);
        if (r_op_we) w_we_n_nxt = 1'b0;
      end
      ST_STROBE: begin
        if (w_tmr_done) w_we_n_nxt = 1'b1;
      end
      ST_HOLD: begin
        w_ce_n_nxt = 1'b1;
        w_ack_nxt  = 1'b1;
      end
      ST_ACCESS: begin
        if (w_tmr_done) begin
          w_rdata_nxt = sram_do;
          w_ce_n_nxt  = 1'b1;
          w_ack_nxt   = 1'b1;
        end
      end
      default: begin
        w_ce_n_nxt = 1'b1;
        w_we_n_nxt = 1'b1;
      end
    endcase
  end

  // Output and operand registers; reset forces the strobes inactive at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_we <= 1'b0;
      r_ready <= 1'b1;
      r_ack   <= 1'b0;
      r_ce_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_a     <= '0;
      r_di    <= '0;
      r_rdata <= '0;
    end else begin
      r_op_we <= w_op_we_nxt;
      r_ready <= w_ready_nxt;
      r_ack   <= w_ack_nxt;
      r_ce_n  <= w_ce_n_nxt;
      r_we_n  <= w_we_n_nxt;
      r_a     <= w_a_nxt;
      r_di    <= w_di_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

`ifdef SRAM_CTRL_PARITY_EN
  logic r_di_p;
  logic r_par_err;

  // Even parity bit travels with the data word; the check is registered on
  // the same edge as rdata so it is valid with ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_di_p    <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (w_accept) r_di_p <= ^wdata;
      if (r_state == ST_ACCESS && w_tmr_done) r_par_err <= (^sram_do) ^ sram_do_p;
    end
  end

  assign sram_di_p = r_di_p;
  assign par_err   = r_par_err;
`endif

  assign ready       = r_ready;
  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign sram_a      = r_a;
  assign sram_ce_n   = r_ce_n;
  assign sram_we_n   = r_we_n;
  assign sram_di     = r_di;
  assign o_dbg_state = r_state;

endmodule
